// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing for load-use, taken branch and data-memory waits
module hazard_ctrl #(
    parameter int REG_W     = 5,
    parameter int CNT_W     = 16,
    parameter int FLUSH_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_pause,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             memwait, lu, squash, br_go;

    assign memwait = mem_req & ~mem_ready;
    assign lu = ex_memread & (ex_rd != '0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    // a memwait that interrupted a squash keeps fcnt, so the squash resumes on release
    assign squash = (state_q == FLUSH) | ((state_q == MEMWAIT) & (fcnt_q != 3'd0));

    always_comb begin
        pc_write    = 1'b1;
        ifid_pause  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        state_d     = RUN;
        fcnt_d      = fcnt_q;
        br_go       = 1'b0;
        if (memwait) begin
            pc_write   = 1'b0;
            ifid_pause = 1'b1;
            pipe_hold  = 1'b1;
            state_d    = MEMWAIT;
        end else if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            br_go       = 1'b1;
            state_d     = (FLUSH_CYC > 1) ? FLUSH : RUN;
            fcnt_d      = (FLUSH_CYC > 1) ? 3'(FLUSH_CYC - 1) : 3'd0;
        end else if (squash) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = (fcnt_q > 3'd1) ? FLUSH : RUN;
            fcnt_d      = fcnt_q - 3'd1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_pause  = 1'b1;
            idex_bubble = 1'b1;
        end
        if (rst) begin
            pc_write    = 1'b0;
            ifid_pause  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_hold   = 1'b0;
        end
        stall_cnt_d = stall_cnt_q + CNT_W'(~pc_write & ~&stall_cnt_q);
        flush_cnt_d = flush_cnt_q + CNT_W'(br_go & ~&flush_cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            fcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule
